// File: rtl/zbb_pkg.sv
// Shared constants and the micro-op record for the Zbb decode/issue stage.
package zbb_pkg;

    localparam logic [4:0] OP_NONE  = 5'd0;
    localparam logic [4:0] OP_CLZ   = 5'd1;
    localparam logic [4:0] OP_CTZ   = 5'd2;
    localparam logic [4:0] OP_MINU  = 5'd4;
    localparam logic [4:0] OP_MAXU  = 5'd5;
    localparam logic [4:0] OP_SEXTH = 5'd6;
    localparam logic [4:0] OP_SEXTB = 5'd7;
    localparam logic [4:0] OP_MAX   = 5'd8;
    localparam logic [4:0] OP_MIN   = 5'd9;
    localparam logic [4:0] OP_ZEXTH = 5'd10;
    localparam logic [4:0] OP_ROL   = 5'd11;
    localparam logic [4:0] OP_ROR   = 5'd12;
    localparam logic [4:0] OP_RORI  = 5'd13;
    localparam logic [4:0] OP_ORCB  = 5'd14;
    localparam logic [4:0] OP_REV8  = 5'd15;
    localparam logic [4:0] OP_CPOP  = 5'd16;
    localparam logic [4:0] OP_ANDN  = 5'd17;
    localparam logic [4:0] OP_ORN   = 5'd18;
    localparam logic [4:0] OP_XNOR  = 5'd19;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_SL  = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_LOGN   = 7'b0100000;
    localparam logic [6:0] F7_MINMAX = 7'b0000101;
    localparam logic [6:0] F7_ROT    = 7'b0110000;
    localparam logic [6:0] F7_ZEXT   = 7'b0000100;

    localparam logic [11:0] IMM_CLZ   = 12'h600;
    localparam logic [11:0] IMM_CTZ   = 12'h601;
    localparam logic [11:0] IMM_CPOP  = 12'h602;
    localparam logic [11:0] IMM_SEXTB = 12'h604;
    localparam logic [11:0] IMM_SEXTH = 12'h605;
    localparam logic [11:0] IMM_ORCB  = 12'h287;
    localparam logic [11:0] IMM_REV8  = 12'h698;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  shamt;
        logic [31:0] word;
        logic        illegal;
    } zbb_uop_t;

endpackage

// File: rtl/zbb_decode_if.sv
// Upstream instruction handshake plus downstream decoded-entry handshake.
// valid/ready: a transfer happens on a rising edge where both are 1; a source holding valid keeps its payload stable until then.
interface zbb_decode_if;
    logic        flush_i;
    logic [31:0] instr_i;
    logic        valid_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  op_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  shamt_o;
    logic [31:0] instr_word_o;
    logic        illegal_o;

    modport slave (
        input  flush_i, instr_i, valid_i, ready_i,
        output ready_o, valid_o, op_o, rd_o, rs1_o, rs2_o, shamt_o, instr_word_o, illegal_o
    );

    modport master (
        output flush_i, instr_i, valid_i, ready_i,
        input  ready_o, valid_o, op_o, rd_o, rs1_o, rs2_o, shamt_o, instr_word_o, illegal_o
    );
endinterface

// File: rtl/zbb_skid_buf.sv
// Two-entry valid/ready buffer: a main output register backed by one skid register.
module zbb_skid_buf
    import zbb_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     flush_i,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  zbb_uop_t in_uop_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output zbb_uop_t out_uop_o
);

    zbb_uop_t main_q, main_d, skid_q, skid_d;
    logic     main_valid_q, main_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     ready_q, ready_d;
    logic     accept, drain;

    assign accept = in_valid_i & ready_q;
    assign drain  = main_valid_q & out_ready_i;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            main_valid_d = skid_valid_q;
            main_d       = skid_valid_q ? skid_q : main_q;
            skid_valid_d = 1'b0;
        end
        // ready_q implies the skid is empty, so an accept never overwrites it
        if (accept) begin
            if (!main_valid_q || drain) begin
                main_d       = in_uop_i;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_uop_i;
                skid_valid_d = 1'b1;
            end
        end
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_valid_q;
    assign out_uop_o   = main_q;

endmodule

// File: rtl/zbb_decode.sv
// Zbb decode/issue stage: classifies RV32 words into ALU op codes and registers them through a skid buffer.
module zbb_decode
    import zbb_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    zbb_decode_if.slave  bus
);

    logic [31:0] w;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic [4:0]  op;
    zbb_uop_t    dec_uop, out_uop;

    assign w      = bus.instr_i;
    assign opcode = w[6:0];
    assign funct3 = w[14:12];
    assign funct7 = w[31:25];
    assign imm12  = w[31:20];

    always_comb begin
        op = OP_NONE;
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_LOGN: begin
                        case (funct3)
                            F3_AND:  op = OP_ANDN;
                            F3_OR:   op = OP_ORN;
                            F3_XOR:  op = OP_XNOR;
                            default: op = OP_NONE;
                        endcase
                    end
                    F7_MINMAX: begin
                        case (funct3)
                            F3_XOR:  op = OP_MIN;
                            F3_SR:   op = OP_MINU;
                            F3_OR:   op = OP_MAX;
                            F3_AND:  op = OP_MAXU;
                            default: op = OP_NONE;
                        endcase
                    end
                    F7_ROT: begin
                        case (funct3)
                            F3_SL:   op = OP_ROL;
                            F3_SR:   op = OP_ROR;
                            default: op = OP_NONE;
                        endcase
                    end
                    // zext.h reuses the pack encoding with rs2 hard-wired to x0
                    F7_ZEXT: if (funct3 == F3_XOR && w[24:20] == 5'd0) op = OP_ZEXTH;
                    default: op = OP_NONE;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3)
                    F3_SL: begin
                        case (imm12)
                            IMM_CLZ:   op = OP_CLZ;
                            IMM_CTZ:   op = OP_CTZ;
                            IMM_CPOP:  op = OP_CPOP;
                            IMM_SEXTB: op = OP_SEXTB;
                            IMM_SEXTH: op = OP_SEXTH;
                            default:   op = OP_NONE;
                        endcase
                    end
                    F3_SR: begin
                        if (funct7 == F7_ROT)        op = OP_RORI;
                        else if (imm12 == IMM_ORCB)  op = OP_ORCB;
                        else if (imm12 == IMM_REV8)  op = OP_REV8;
                    end
                    default: op = OP_NONE;
                endcase
            end
            default: op = OP_NONE;
        endcase
    end

    assign dec_uop = '{op: op, rd: w[11:7], rs1: w[19:15], rs2: w[24:20],
                       shamt: w[24:20], word: w, illegal: (op == OP_NONE)};

    zbb_skid_buf u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (bus.flush_i),
        .in_valid_i  (bus.valid_i),
        .in_ready_o  (bus.ready_o),
        .in_uop_i    (dec_uop),
        .out_valid_o (bus.valid_o),
        .out_ready_i (bus.ready_i),
        .out_uop_o   (out_uop)
    );

    assign bus.op_o         = out_uop.op;
    assign bus.rd_o         = out_uop.rd;
    assign bus.rs1_o        = out_uop.rs1;
    assign bus.rs2_o        = out_uop.rs2;
    assign bus.shamt_o      = out_uop.shamt;
    assign bus.instr_word_o = out_uop.word;
    assign bus.illegal_o    = out_uop.illegal;

endmodule

// File: tb/tb_zbb_decode.sv
// Bench for zbb_decode: mask/match instruction table model plus an occupancy queue for the buffer.
module tb_zbb_decode;
  logic clk;
  logic rst_ni;
  int   n_chk;
  int   n_fail;
  logic last_acc;
  logic [57:0] exp_q[$];

  zbb_decode_if bus ();

  zbb_decode dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zbb encodings as (mask, match, op) triples
  localparam int NPAT = 18;
  localparam logic [31:0] PAT_MASK [NPAT] = '{
    32'hFFF0707F, 32'hFFF0707F, 32'hFFF0707F, 32'hFFF0707F, 32'hFFF0707F,
    32'hFFF0707F, 32'hFFF0707F, 32'hFFF0707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F};
  localparam logic [31:0] PAT_MATCH [NPAT] = '{
    32'h60001013, 32'h60101013, 32'h60201013, 32'h60401013, 32'h60501013,
    32'h08004033, 32'h28705013, 32'h69805013,
    32'h40007033, 32'h40006033, 32'h40004033, 32'h0A004033, 32'h0A005033,
    32'h0A006033, 32'h0A007033, 32'h60001033, 32'h60005033, 32'h60005013};
  localparam logic [4:0] PAT_OP [NPAT] = '{
    5'd1, 5'd2, 5'd16, 5'd7, 5'd6,
    5'd10, 5'd14, 5'd15,
    5'd17, 5'd18, 5'd19, 5'd9, 5'd4,
    5'd8, 5'd5, 5'd11, 5'd12, 5'd13};

  function automatic logic [57:0] model(input logic [31:0] w);
    logic [4:0] op;
    op = 5'd0;
    for (int i = 0; i < NPAT; i++)
      if ((w & PAT_MASK[i]) == PAT_MATCH[i]) op = PAT_OP[i];
    return {op, w[11:7], w[19:15], w[24:20], w[24:20], w, (op == 5'd0)};
  endfunction

  function automatic logic [57:0] dut_vec();
    return {bus.op_o, bus.rd_o, bus.rs1_o, bus.rs2_o, bus.shamt_o, bus.instr_word_o, bus.illegal_o};
  endfunction

  function automatic logic [31:0] rand_word();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, NPAT - 1);
    case ($urandom_range(0, 3))
      0:       w = $urandom;
      3:       w = PAT_MATCH[k] ^ (PAT_MASK[k] & (32'h1 << $urandom_range(0, 31)));
      default: w = PAT_MATCH[k] | ($urandom & ~PAT_MASK[k]);
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: update the scoreboard from the handshake, then check after the edge.
  task automatic cycle();
    logic acc;
    logic rst_s;
    acc   = bus.valid_i & bus.ready_o;
    rst_s = rst_ni;
    if (bus.valid_o && rst_ni) begin
      chk("out_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("out_fields", dut_vec(), exp_q[0]);
    end
    if (!rst_ni || bus.flush_i) exp_q.delete();
    else begin
      if (bus.valid_o && bus.ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(model(bus.instr_i));
    end
    last_acc = acc & rst_ni & ~bus.flush_i;
    @(posedge clk);
    #1;
    chk("valid_o", bus.valid_o, exp_q.size() > 0);
    chk("ready_o", bus.ready_o, rst_s && exp_q.size() < 2);
    if (!rst_s) chk("reset_fields", dut_vec(), 58'd0);
  endtask

  task automatic directed(input logic [31:0] w, input logic [4:0] exp_op, input logic exp_ill);
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.instr_i = w;
    cycle();
    bus.valid_i = 1'b0;
    chk("dir_valid", bus.valid_o, 1);
    chk("dir_op", bus.op_o, exp_op);
    chk("dir_illegal", bus.illegal_o, exp_ill);
    chk("dir_word", bus.instr_word_o, w);
  endtask

  initial begin
    int sent;
    logic [31:0] words[4];
    n_chk = 0;
    n_fail = 0;
    last_acc = 1'b0;
    rst_ni = 1'b0;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.instr_i = 32'd0;
    cycle();
    cycle();
    rst_ni = 1'b1;
    cycle();
    chk("ready_after_reset", bus.ready_o, 1);

    // directed decodes
    directed(32'h4020F1B3, 5'd17, 1'b0);
    chk("andn_rd", bus.rd_o, 3);
    chk("andn_rs1", bus.rs1_o, 1);
    chk("andn_rs2", bus.rs2_o, 2);
    directed(32'h60735293, 5'd13, 1'b0);
    chk("rori_shamt", bus.shamt_o, 7);
    chk("rori_rd", bus.rd_o, 5);
    chk("rori_rs1", bus.rs1_o, 6);
    directed(32'h6980D093, 5'd15, 1'b0);
    directed(32'h2870D093, 5'd14, 1'b0);
    directed(32'h003100B3, 5'd0, 1'b1);
    directed(32'h08004033, 5'd10, 1'b0);
    directed(32'h08104033, 5'd0, 1'b1);
    cycle();

    // backpressure: four words, downstream stalled for three cycles
    for (int i = 0; i < 4; i++) words[i] = rand_word();
    sent = 0;
    bus.ready_i = 1'b0;
    for (int t = 0; t < 40 && sent < 4; t++) begin
      bus.valid_i = 1'b1;
      bus.instr_i = words[sent];
      bus.ready_i = (t >= 3);
      cycle();
      if (t == 1) chk("stall_ready_low", bus.ready_o, 0);
      if (last_acc) sent++;
    end
    bus.valid_i = 1'b0;
    chk("bp_sent", sent, 4);
    bus.ready_i = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) cycle();
    chk("bp_drained", exp_q.size(), 0);

    // flush with both entries full and an incoming word
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.instr_i = rand_word();
    cycle();
    bus.instr_i = rand_word();
    cycle();
    bus.flush_i = 1'b1;
    bus.instr_i = rand_word();
    cycle();
    chk("flush_valid", bus.valid_o, 0);
    chk("flush_ready", bus.ready_o, 1);
    bus.flush_i = 1'b0;
    bus.instr_i = rand_word();
    cycle();
    bus.flush_i = 1'b1;
    bus.instr_i = rand_word();
    cycle();
    chk("flush_drop_accept", bus.valid_o, 0);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.valid_i && !last_acc)) begin
        bus.valid_i = ($urandom_range(0, 9) < 7);
        bus.instr_i = rand_word();
      end
      bus.ready_i = ($urandom_range(0, 9) < 6);
      bus.flush_i = ($urandom_range(0, 99) < 2);
      cycle();
    end
    bus.flush_i = 1'b0;

    // reset mid-stream
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b0;
    bus.instr_i = rand_word();
    cycle();
    bus.instr_i = rand_word();
    cycle();
    rst_ni = 1'b0;
    cycle();
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    cycle();
    rst_ni = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    cycle();
    chk("ready_after_rst2", bus.ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/zbb_decode.md
# zbb_decode

Registered decode/issue stage in front of the Zbb ALU. It accepts 32-bit RV32 instruction words over a valid/ready handshake and classifies each as a Zbb operation. Each accepted word is presented downstream with the ALU's 5-bit operation code, register indices, shift amount and an illegal flag. A two-entry skid buffer gives full throughput with a registered upstream ready.

## Interface
- No parameters. Op-code constants come from `zbb_pkg`.
- `clk_i  in  1`: clock, rising edge.
- `rst_ni  in  1`: synchronous, active-low reset.
- `flush_i  in  1`: discards all held entries.
- `instr_i  in  32`: instruction word.
- `valid_i  in  1`: `instr_i` is valid.
- `ready_o  out  1`: stage can accept. Reset value 0.
- `valid_o  out  1`: output entry valid. Reset value 0.
- `ready_i  in  1`: downstream accepts.
- `op_o  out  5`: ALU operation code. Reset value 0.
- `rd_o`, `rs1_o`, `rs2_o  out  5 each`: register indices from bits [11:7], [19:15], [24:20]. Reset value 0.
- `shamt_o  out  5`: bits [24:20]. Reset value 0.
- `instr_word_o  out  32`: word passed through unchanged. Reset value 0.
- `illegal_o  out  1`: word is not a recognised Zbb instruction. Reset value 0.

## Operation
- Op codes:
  - 0 none
  - 1 clz, 2 ctz, 3 reserved
  - 4 minu, 5 maxu, 6 sext.h, 7 sext.b, 8 max, 9 min, 10 zext.h
  - 11 rol, 12 ror, 13 rori, 14 orc.b, 15 rev8
  - 16 cpop, 17 andn, 18 orn, 19 xnor
- Decode for OP (opcode 0110011), as funct7 / funct3:
  - andn 0100000/111, orn 0100000/110, xnor 0100000/100
  - min 0000101/100, minu 0000101/101, max 0000101/110, maxu 0000101/111
  - rol 0110000/001, ror 0110000/101
  - zext.h 0000100/100, with rs2 = 0
- Decode for OP-IMM (opcode 0010011):
  - funct3 001: imm12 0x600 clz, 0x601 ctz, 0x602 cpop, 0x604 sext.b, 0x605 sext.h
  - funct3 101: imm[11:5] 0110000 rori; imm12 0x287 orc.b; imm12 0x698 rev8
- Anything else sets `illegal_o`=1 and `op_o`=0. Illegal words are still forwarded so the core can trap.
- Decode is combinational on `instr_i` and is registered at acceptance.
- Storage is a main output register plus a skid register.
- Accept occurs when `valid_i & ready_o`. The decoded entry goes to the main register if it is empty or draining this cycle; otherwise it goes to the skid register.
- Drain occurs when `valid_o & ready_i`. A held skid entry then moves into the main register in the same cycle.
- `ready_o` = `rst_ni & ~skid_valid`. It is driven by a flop, so there is no combinational path from `ready_i`.
- Output fields of a valid entry stay stable until drained.
- `flush_i` clears both entries at the next edge and takes priority over a simultaneous accept, which is dropped.
- Reset takes priority over `flush_i`. Reset mid-stream drops all entries, and all outputs take their reset values at the next edge.

## Timing
- Latency: word accepted at edge N appears with `valid_o`=1 after edge N. One cycle, no bubbles.
- Throughput: one word per cycle while `ready_i`=1.
- Stall sequence:
  - First stalled cycle: the skid absorbs one word.
  - Following cycle: `ready_o`=0.
  - `ready_o` returns to 1 one cycle after the skid drains.
- `ready_o`=1 the first cycle after `rst_ni` rises.
- Simultaneous accept and drain with an empty skid: main register is replaced and the skid stays empty.

## Structure
- `zbb_pkg` holds:
  - the 5-bit op-code localparams (`OP_CLZ` … `OP_XNOR`)
  - opcode, funct3 and funct7 constants
  - imm12 constants 0x600, 0x601, 0x602, 0x604, 0x605, 0x287, 0x698
  - a packed struct `zbb_uop_t` {op, rd, rs1, rs2, shamt, word, illegal}
- One sub-module, `zbb_skid_buf`, is the two-entry valid/ready buffer carrying `zbb_uop_t`.
- Decode logic stays in `zbb_decode`.

## Test plan
- andn x3,x1,x2 (0x4020F1B3):
  - `op_o`=17, `rd_o`=3, `rs1_o`=1, `rs2_o`=2, `illegal_o`=0, one cycle later.
- rori x5,x6,7 (0x60735293):
  - `op_o`=13, `shamt_o`=7, `rd_o`=5, `rs1_o`=6.
- rev8 x1,x1 (0x6980D093):
  - `op_o`=15.
- Same test, orc.b variant 0x2870D093:
  - `op_o`=14.
- add x1,x2,x3 (0x003100B3):
  - `illegal_o`=1, `op_o`=0, `instr_word_o`=0x003100B3.
- Backpressure, four back-to-back words with `ready_i`=0 for three cycles:
  - `ready_o` falls one cycle into the stall.
  - All four words emerge in order with no loss or duplication.
- Flush and reset:
  - `flush_i` with both entries full and `valid_i`=1: next cycle `valid_o`=0 and `ready_o`=1.
  - `rst_ni`=0 mid-stream: all outputs at reset values and `ready_o`=0 during reset.
